// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : rect_fill_engine
// Purpose  : Avalon-MM slave that fills an axis-aligned rectangle of a
//            640x480 8bpp linear framebuffer with a constant colour, emitting
//            one registered framebuffer write per clock in raster order.
// Ports    : clk, reset (async, active-high)
//            chipselect/write/read/address/writedata/readdata : Avalon slave
//            fb_addr/fb_data/fb_we : framebuffer write port (registered)
//            busy : high while a fill is being set up or executed
// Revision : 1.0 - initial release
// ============================================================================
module rect_fill_engine #(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [3:0]        address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  localparam logic [9:0]        c_XLAST  = 10'(HRES - 1);
  localparam logic [9:0]        c_YLAST  = 10'(VRES - 1);
  localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(HRES);

  state_t r_state, w_state_next;

  // Software-visible registers
  logic [7:0]        r_color;
  logic [9:0]        r_x0, r_y0, r_x1, r_y1;
  logic              r_start_pend;
  logic [7:0]        r_readdata;

  // Fill operands, latched in SETUP so register writes cannot disturb a fill
  logic [9:0]        r_xmin, r_xmax, r_ymax, r_x, r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [7:0]        r_fb_data;
  logic              r_fb_we;

  logic              w_wr, w_start_acc;
  logic [9:0]        w_xmin, w_xmax, w_ymin, w_ymax, w_xmax_c, w_ymax_c;
  logic              w_offscreen, w_x_last, w_y_last;
  logic [ADDR_W-1:0] w_ymin_ext, w_row0, w_first_addr;
  logic [7:0]        w_rd_mux;

  assign w_wr = chipselect && write;
  // A START is only taken from a quiet IDLE; the pending flag also blocks a
  // second START landing in the cycle before the FSM leaves IDLE.
  assign w_start_acc = w_wr && (address == 4'h9) && (r_state == S_IDLE) && !r_start_pend;

  assign w_xmin   = (r_x0 < r_x1) ? r_x0 : r_x1;
  assign w_xmax   = (r_x0 < r_x1) ? r_x1 : r_x0;
  assign w_ymin   = (r_y0 < r_y1) ? r_y0 : r_y1;
  assign w_ymax   = (r_y0 < r_y1) ? r_y1 : r_y0;
  assign w_xmax_c = (w_xmax > c_XLAST) ? c_XLAST : w_xmax;
  assign w_ymax_c = (w_ymax > c_YLAST) ? c_YLAST : w_ymax;
  assign w_offscreen = (w_xmin > c_XLAST) || (w_ymin > c_YLAST);

  assign w_ymin_ext = ADDR_W'(w_ymin);
  generate
    if (HRES == 640) begin : g_row_shift
      // y*640 = y*512 + y*128
      assign w_row0 = (w_ymin_ext << 9) + (w_ymin_ext << 7);
    end else begin : g_row_mul
      assign w_row0 = w_ymin_ext * c_STRIDE;
    end
  endgenerate
  assign w_first_addr = w_row0 + ADDR_W'(w_xmin);

  assign w_x_last = (r_x >= r_xmax);
  assign w_y_last = (r_y >= r_ymax);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (r_start_pend) w_state_next = S_SETUP;
      S_SETUP: w_state_next = w_offscreen ? S_IDLE : S_FILL;
      S_FILL:  if (w_x_last && w_y_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fill datapath. The output registers are loaded on the edge that enters
  // each pixel, so fb_we falls on the same edge the FSM returns to IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_fb_addr  <= '0;
      r_fb_data  <= '0;
      r_fb_we    <= 1'b0;
    end else begin
      unique case (r_state)
        S_SETUP: begin
          r_xmin     <= w_xmin;
          r_xmax     <= w_xmax_c;
          r_ymax     <= w_ymax_c;
          r_x        <= w_xmin;
          r_y        <= w_ymin;
          r_row_base <= w_row0;
          if (!w_offscreen) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= w_first_addr;
            r_fb_data <= r_color;
          end
        end
        S_FILL: begin
          if (!w_x_last) begin
            r_x       <= r_x + 10'd1;
            r_fb_addr <= r_fb_addr + ADDR_W'(1);
          end else if (!w_y_last) begin
            r_x        <= r_xmin;
            r_y        <= r_y + 10'd1;
            r_row_base <= r_row_base + c_STRIDE;
            r_fb_addr  <= r_row_base + c_STRIDE + ADDR_W'(r_xmin);
          end else begin
            r_fb_we <= 1'b0;
          end
        end
        default: r_fb_we <= 1'b0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file and registered read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_color      <= '0;
      r_x0         <= '0;
      r_y0         <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_start_pend <= 1'b0;
    end else begin
      r_start_pend <= w_start_acc;
      if (w_wr) begin
        case (address)
          4'h0: r_color      <= writedata;
          4'h1: r_x0[9:8]    <= writedata[1:0];
          4'h2: r_x0[7:0]    <= writedata;
          4'h3: r_y0[9:8]    <= writedata[1:0];
          4'h4: r_y0[7:0]    <= writedata;
          4'h5: r_x1[9:8]    <= writedata[1:0];
          4'h6: r_x1[7:0]    <= writedata;
          4'h7: r_y1[9:8]    <= writedata[1:0];
          4'h8: r_y1[7:0]    <= writedata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_mux = 8'h00;
    case (address)
      4'h0: w_rd_mux = r_color;
      4'h1: w_rd_mux = {6'b0, r_x0[9:8]};
      4'h2: w_rd_mux = r_x0[7:0];
      4'h3: w_rd_mux = {6'b0, r_y0[9:8]};
      4'h4: w_rd_mux = r_y0[7:0];
      4'h5: w_rd_mux = {6'b0, r_x1[9:8]};
      4'h6: w_rd_mux = r_x1[7:0];
      4'h7: w_rd_mux = {6'b0, r_y1[9:8]};
      4'h8: w_rd_mux = r_y1[7:0];
      4'h9: w_rd_mux = {7'b0, busy};
      default: w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_readdata <= '0;
    else if (chipselect && read) r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign fb_addr  = r_fb_addr;
  assign fb_data  = r_fb_data;
  assign fb_we    = r_fb_we;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_fill_engine
// Purpose  : Self-checking bench for rect_fill_engine: directed vector table,
//            hand-written timing/corner sequences and randomized rectangles
//            compared against a raster-order reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_fill_engine;

  localparam int HRES = 640;
  localparam int VRES = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [3:0]  address = 4'h0;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  int   cap_addr[$];
  int   cap_data[$];
  int   exp_q[$];
  int   busy_cyc = 0;
  int   runs = 0;
  int   we_wo_busy = 0;
  logic prev_we = 1'b0;

  typedef struct {
    int x0, y0, x1, y1, col;
    int cnt, first, last, bcyc;
  } vec_t;

  vec_t tv[7];

  always #5 clk = ~clk;

  rect_fill_engine #(.HRES(640), .VRES(480), .ADDR_W(19)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata),
    .readdata(readdata), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_we(fb_we), .busy(busy)
  );

  // Framebuffer-side observer, sampled mid-cycle
  always @(negedge clk) begin
    if (fb_we) begin
      cap_addr.push_back(int'(fb_addr));
      cap_data.push_back(int'(fb_data));
      if (!prev_we) runs++;
      if (!busy) we_wo_busy++;
    end
    if (busy) busy_cyc++;
    prev_we = fb_we;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    cap_addr.delete();
    cap_data.delete();
    busy_cyc = 0;
    runs = 0;
    we_wo_busy = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output int v);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    v = int'(readdata);
  endtask

  task automatic set_rect(input int x0, input int y0, input int x1, input int y1);
    logic [9:0] t;
    t = x0[9:0]; wr(4'h1, {6'b0, t[9:8]}); wr(4'h2, t[7:0]);
    t = y0[9:0]; wr(4'h3, {6'b0, t[9:8]}); wr(4'h4, t[7:0]);
    t = x1[9:0]; wr(4'h5, {6'b0, t[9:8]}); wr(4'h6, t[7:0]);
    t = y1[9:0]; wr(4'h7, {6'b0, t[9:8]}); wr(4'h8, t[7:0]);
  endtask

  // Called right after the START write; busy is guaranteed high one cycle later.
  task automatic wait_idle(input string name);
    bit to;
    to = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
    check({name, "_finished"}, int'(to), 0);
  endtask

  // Reference model: the set of pixels a fill covers, in raster order.
  task automatic build_exp(input int x0, input int y0, input int x1, input int y1);
    int xa, xb, ya, yb;
    exp_q.delete();
    xa = (x0 < x1) ? x0 : x1;  xb = (x0 < x1) ? x1 : x0;
    ya = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
    if (xb > HRES - 1) xb = HRES - 1;
    if (yb > VRES - 1) yb = VRES - 1;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        exp_q.push_back(y * HRES + x);
  endtask

  task automatic verify(input string name, input int col);
    int mi, bad_d, n;
    n = exp_q.size();
    check({name, "_count"}, cap_addr.size(), n);
    mi = -1;
    for (int i = 0; i < n && i < cap_addr.size(); i++)
      if (cap_addr[i] != exp_q[i]) begin mi = i; break; end
    check({name, "_addr_seq_first_bad_idx"}, mi, -1);
    bad_d = 0;
    foreach (cap_data[i]) if (cap_data[i] != col) bad_d++;
    check({name, "_bad_data_pixels"}, bad_d, 0);
    check({name, "_we_runs"}, runs, (n > 0) ? 1 : 0);
    check({name, "_busy_cycles"}, busy_cyc, (n > 0) ? n + 1 : 1);
    check({name, "_we_without_busy"}, we_wo_busy, 0);
  endtask

  initial begin
    int v;
    int x0, y0, x1, y1, col;
    logic [7:0] c8;

    tv[0] = '{5, 0, 5, 0, 8'h7F, 1, 5, 5, 2};
    tv[1] = '{10, 5, 12, 6, 8'hAB, 6, 3210, 3852, 7};
    tv[2] = '{12, 6, 10, 5, 8'hAB, 6, 3210, 3852, 7};
    tv[3] = '{630, 478, 700, 500, 8'h3C, 20, 306550, 307199, 21};
    tv[4] = '{640, 0, 640, 0, 8'h99, 0, -1, -1, 1};
    tv[5] = '{0, 480, 5, 490, 8'h42, 0, -1, -1, 1};
    tv[6] = '{0, 100, 639, 100, 8'hE1, 640, 64000, 64639, 641};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_readdata", int'(readdata), 0);
    check("rst_busy", int'(busy), 0);
    for (int a = 0; a < 16; a++) begin
      rd(a[3:0], v);
      check($sformatf("rst_reg%0d", a), v, 0);
    end

    // register readback incl. hi-byte masking
    wr(4'h1, 8'hFE);
    rd(4'h1, v); check("reg_x0hi_masked", v, 2);
    wr(4'h0, 8'h5A);
    rd(4'h0, v); check("reg_color", v, 8'h5A);

    // ---------------- start latency + START on final pixel ----------------
    set_rect(5, 0, 5, 0);
    wr(4'h0, 8'h7F);
    clear_mon();
    wr(4'h9, 8'h00);              // START sampled at edge T; now after T
    @(negedge clk);               // after T+1
    check("lat_busy_T1", int'(busy), 1);
    check("lat_we_T1", int'(fb_we), 0);
    @(negedge clk);               // after T+2
    check("lat_we_T2", int'(fb_we), 1);
    check("lat_addr_T2", int'(fb_addr), 5);
    check("lat_data_T2", int'(fb_data), 8'h7F);
    chipselect = 1'b1; write = 1'b1; address = 4'h9;   // START during last pixel
    @(negedge clk);               // after T+3
    chipselect = 1'b0; write = 1'b0;
    check("lat_we_T3", int'(fb_we), 0);
    check("lat_busy_T3", int'(busy), 0);
    repeat (6) @(negedge clk);
    check("late_start_ignored_pixels", cap_addr.size(), 1);
    check("late_start_ignored_busy", busy_cyc, 2);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 7; i++) begin
      set_rect(tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1);
      c8 = tv[i].col[7:0];
      wr(4'h0, c8);
      clear_mon();
      wr(4'h9, 8'h00);
      wait_idle($sformatf("tv%0d", i));
      check($sformatf("tv%0d_cnt", i), cap_addr.size(), tv[i].cnt);
      check($sformatf("tv%0d_first", i), (cap_addr.size() > 0) ? cap_addr[0] : -1, tv[i].first);
      check($sformatf("tv%0d_last", i), (cap_addr.size() > 0) ? cap_addr[cap_addr.size()-1] : -1, tv[i].last);
      check($sformatf("tv%0d_busy", i), busy_cyc, tv[i].bcyc);
      build_exp(tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1);
      verify($sformatf("tv%0d", i), tv[i].col);
    end

    // ---------------- busy semantics on a 100x100 fill ----------------
    set_rect(0, 0, 99, 99);
    wr(4'h0, 8'h11);
    clear_mon();
    wr(4'h9, 8'h00);
    repeat (20) @(negedge clk);
    wr(4'h0, 8'h22);              // colour change must not affect this fill
    wr(4'h9, 8'h00);              // ignored, engine busy
    rd(4'h9, v);
    check("busy_read_during", v, 1);
    wait_idle("big");
    build_exp(0, 0, 99, 99);
    verify("big", 8'h11);
    rd(4'h9, v);
    check("busy_read_after", v, 0);
    set_rect(3, 3, 3, 3);
    clear_mon();
    wr(4'h9, 8'h00);
    wait_idle("newcol");
    build_exp(3, 3, 3, 3);
    verify("newcol", 8'h22);

    // ---------------- randomized rectangles ----------------
    for (int it = 0; it < 30; it++) begin
      x0 = $urandom_range(0, 700);
      y0 = $urandom_range(0, 520);
      x1 = ($urandom_range(0, 1) != 0) ? x0 + $urandom_range(0, 24) : x0 - $urandom_range(0, 24);
      y1 = ($urandom_range(0, 1) != 0) ? y0 + $urandom_range(0, 16) : y0 - $urandom_range(0, 16);
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      col = $urandom_range(0, 255);
      set_rect(x0, y0, x1, y1);
      c8 = col[7:0];
      wr(4'h0, c8);
      clear_mon();
      wr(4'h9, 8'h00);
      wait_idle($sformatf("rnd%0d", it));
      build_exp(x0, y0, x1, y1);
      verify($sformatf("rnd%0d(%0d,%0d)-(%0d,%0d)", it, x0, y0, x1, y1), col);
    end

    // ---------------- reset mid-fill ----------------
    set_rect(0, 0, 99, 99);
    wr(4'h0, 8'h55);
    clear_mon();
    wr(4'h9, 8'h00);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (cap_addr.size() >= 50) break;
    end
    check("midrst_reached_50", cap_addr.size(), 50);
    #1 reset = 1'b1;
    #1;
    check("midrst_we_async", int'(fb_we), 0);
    check("midrst_busy_async", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_more_pixels", cap_addr.size(), 50);
    for (int a = 0; a < 10; a++) begin
      rd(a[3:0], v);
      check($sformatf("midrst_reg%0d", a), v, 0);
    end
    clear_mon();
    wr(4'h9, 8'h00);
    wait_idle("postrst");
    build_exp(0, 0, 0, 0);
    verify("postrst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rect_fill_engine.md
# rect_fill_engine

Avalon-MM slave that fills axis-aligned rectangles of the 640x480, 8-bit-per-pixel framebuffer with a constant colour. Software loads corner coordinates and a colour, then writes a start command. The engine then emits one framebuffer write per clock (address, data, write-enable) into the framebuffer memory's write port. The VGA scan-out side reads that memory independently. Software polls a busy bit to know when the fill is done.

## Interface
Parameters:
- HRES, 640, visible pixels per line; also the row stride in the linear framebuffer address.
- VRES, 480, visible lines.
- ADDR_W, 19, framebuffer address width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high; one clock domain only.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  4  register index.
- writedata  in  8  write data.
- readdata  out  8  read data, registered.
- fb_addr  out  ADDR_W  framebuffer write address, y*HRES + x.
- fb_data  out  8  pixel value.
- fb_we  out  1  framebuffer write enable, one pixel per asserted cycle.
- busy  out  1  fill in progress.

## Operation
Register map (writes require chipselect && write):
- 0x0 COLOR[7:0].
- 0x1 X0[9:8], 0x2 X0[7:0].
- 0x3 Y0[9:8], 0x4 Y0[7:0].
- 0x5 X1[9:8], 0x6 X1[7:0].
- 0x7 Y1[9:8], 0x8 Y1[7:0].
- For the hi-byte registers, writedata[7:2] are ignored.
- 0x9 START: writing any value starts a fill, but only when the engine is in IDLE. A START write outside IDLE is ignored entirely.
- Register writes outside START are accepted in any state. They do not affect a fill in progress, because the fill operands are latched in SETUP.
- Reads: 0x9 returns {7'b0, busy}; 0x0–0x8 return the stored register value (hi bytes zero-extended); 0xA–0xF return 0.

FSM:
- IDLE → SETUP on an accepted START.
- SETUP (one cycle) latches:
  - xmin = min(X0,X1), xmax = max(X0,X1), and likewise ymin/ymax;
  - the colour;
  - xmax clamped to HRES-1, ymax clamped to VRES-1.
- SETUP exit:
  - if xmin > HRES-1 or ymin > VRES-1, no pixels are written and the next state is IDLE;
  - otherwise the next state is FILL with x=xmin, y=ymin, row_base=ymin*HRES.
  - row_base is computed once in SETUP (shift-add: y*512 + y*128); no multiplier is used in FILL.
- FILL, each cycle:
  - emit fb_we=1, fb_addr=row_base+x, fb_data=colour;
  - if x<xmax, x++;
  - else if y<ymax, x=xmin, y++, row_base+=HRES;
  - else go to IDLE.
- Pixel order is raster order: left to right within a row, rows top to bottom.
- Total pixels written = (xmax-xmin+1)*(ymax-ymin+1) after clamping.
- busy = (state != IDLE).

Arithmetic: coordinates are 10-bit unsigned. row_base and fb_addr are ADDR_W bits; the maximum address is 307199, which never wraps.

## Timing
- Reset (async assert, sync deassert to clk):
  - outputs: fb_we=0, fb_addr=0, fb_data=0, readdata=0, busy=0;
  - state: IDLE;
  - registers: all coordinate registers and COLOR = 0.
- Reset asserted mid-fill aborts immediately. No further fb_we pulses are produced, and fb_we deasserts asynchronously.
- fb_addr, fb_data and fb_we are registered outputs.
- Start latency, with the START write sampled at edge T:
  - busy=1 after edge T+1 (SETUP);
  - the first fb_we is high in the cycle after edge T+2.
- Throughput: exactly one pixel per clock, with no bubbles at row transitions.
- Completion:
  - busy drops in the same cycle fb_we drops after the last pixel;
  - for an off-screen rectangle, busy is high for exactly one cycle (SETUP) and fb_we never asserts.
- readdata: valid in the cycle after the read strobe. A read of 0x9 reflects busy as of the strobe edge.
- A START in the same cycle as the final FILL pixel is ignored, because the state is not yet IDLE.

## Test plan
- Single pixel: X0=X1=5, Y0=Y1=0, COLOR=0x7F, START → exactly 1 fb_we, with fb_addr=5 and fb_data=0x7F; busy high for 2 cycles total.
- 3x2 rectangle: X0=10, X1=12, Y0=5, Y1=6, COLOR=0xAB → 6 consecutive fb_we with addresses 3210, 3211, 3212, 3850, 3851, 3852; first fb_we 2 cycles after START.
- Swapped corners: X0=12, X1=10, Y0=6, Y1=5 → write sequence identical to the previous scenario.
- Clipping: X=630..700, Y=478..500 → 20 writes, first 306550, last 307199. X0=X1=640 → zero writes, busy pulse of 1 cycle.
- Busy semantics:
  - START during a 100x100 fill → ignored, exactly 10000 writes total;
  - COLOR rewritten mid-fill → fb_data unchanged until the next fill;
  - reading 0x9 returns 1 during the fill and 0 after it.
- Reset mid-fill: assert reset after 50 writes → fb_we=0 immediately, busy=0, all registers read 0; a subsequent START fills (0,0) only.
